// File: rtl/register_file_pkg.sv
// Shared core constants: register-file geometry defaults and write-back opcode/fcode values.
package register_file_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_RA_ADDR = 31;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] fcode_t;

  // Instructions whose results are committed through the write-back port
  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_JAL   = 6'h03;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_LW    = 6'h23;

  localparam fcode_t FC_JALR = 6'h09;
  localparam fcode_t FC_ADD  = 6'h20;
  localparam fcode_t FC_SUB  = 6'h22;
  localparam fcode_t FC_AND  = 6'h24;
  localparam fcode_t FC_OR   = 6'h25;

endpackage

// File: rtl/rf_bypass.sv
// Write-through bypass for one read port: forwards the in-flight write-back
// data when it targets the register being read.
module rf_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_rdAddr,
  input  logic [DATA_W-1:0] i_rdData,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  output logic [DATA_W-1:0] o_data
);

  logic w_hit;

  assign w_hit  = i_wrEn && (i_wrAddr == i_rdAddr);
  assign o_data = w_hit ? i_wrData : i_rdData;

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with write-through bypass, return-address tap,
// one-cycle debug read port and a committed-write counter.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RA_ADDR = DEF_RA_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  output logic [DATA_W-1:0] rsData,
  output logic [DATA_W-1:0] rtData,
  output logic [DATA_W-1:0] raData,
  input  logic              dbgReq,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData,
  output logic              dbgValid,
  output logic [31:0]       wrCount
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] RA_IDX = ADDR_W'(RA_ADDR);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [31:0]       r_wrCount;
  logic [DATA_W-1:0] r_dbgData;
  logic              r_dbgValid;
  logic [DATA_W-1:0] w_dbgPost;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (RegWrite) begin
      r_regs[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrCount <= '0;
    end else if (RegWrite) begin
      r_wrCount <= r_wrCount + 32'd1;
    end
  end

  // Debug capture sees the value the register holds after this edge's write
  assign w_dbgPost = (RegWrite && (wrAddr == dbgAddr)) ? wrData : r_regs[dbgAddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbgData  <= '0;
      r_dbgValid <= 1'b0;
    end else begin
      r_dbgValid <= dbgReq;
      if (dbgReq) begin
        r_dbgData <= w_dbgPost;
      end
    end
  end

  rf_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypassRs (
    .i_rdAddr (rsAddr),
    .i_rdData (r_regs[rsAddr]),
    .i_wrEn   (RegWrite),
    .i_wrAddr (wrAddr),
    .i_wrData (wrData),
    .o_data   (rsData)
  );

  rf_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypassRt (
    .i_rdAddr (rtAddr),
    .i_rdData (r_regs[rtAddr]),
    .i_wrEn   (RegWrite),
    .i_wrAddr (wrAddr),
    .i_wrData (wrData),
    .o_data   (rtData)
  );

  rf_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypassRa (
    .i_rdAddr (RA_IDX),
    .i_rdData (r_regs[RA_IDX]),
    .i_wrEn   (RegWrite),
    .i_wrAddr (wrAddr),
    .i_wrData (wrData),
    .o_data   (raData)
  );

  assign wrCount  = r_wrCount;
  assign dbgData  = r_dbgData;
  assign dbgValid = r_dbgValid;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a register/counter model plus a queue of
// expected debug read data popped when the debug port returns data.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rsAddr;
  logic [4:0]  rtAddr;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] raData;
  logic        dbgReq;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;
  logic        dbgValid;
  logic [31:0] wrCount;

  logic [31:0] mReg [32];
  logic [31:0] mCount;
  logic [31:0] expQ [$];
  logic [31:0] expVal;
  int          errors = 0;
  int          checks = 0;

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .rsAddr   (rsAddr),
    .rtAddr   (rtAddr),
    .rsData   (rsData),
    .rtData   (rtData),
    .raData   (raData),
    .dbgReq   (dbgReq),
    .dbgAddr  (dbgAddr),
    .dbgData  (dbgData),
    .dbgValid (dbgValid),
    .wrCount  (wrCount)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge, so the rising edge always sees stable values
  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1;
    wrAddr   = a;
    wrData   = d;
    @(posedge clk);
    mReg[a] = d;
    mCount  = mCount + 32'd1;
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (rsData !== 32'd0) begin errors++; $display("[TB] FAIL reset_rs actual=%h required=%h", rsData, 32'd0); end
    checks++; if (raData !== 32'd0) begin errors++; $display("[TB] FAIL reset_ra actual=%h required=%h", raData, 32'd0); end
    checks++; if (wrCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_count actual=%h required=%h", wrCount, 32'd0); end
    checks++; if (dbgValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbgvalid actual=%b required=0", dbgValid); end
    checks++; if (dbgData !== 32'd0) begin errors++; $display("[TB] FAIL reset_dbgdata actual=%h required=%h", dbgData, 32'd0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    doWrite(5'd5, 32'hDEADBEEF);
    rsAddr = 5'd5;
    rtAddr = 5'd5;
    #1;
    checks++; if (rsData !== mReg[5]) begin errors++; $display("[TB] FAIL rd_rs5 actual=%h required=%h", rsData, mReg[5]); end
    checks++; if (rtData !== mReg[5]) begin errors++; $display("[TB] FAIL rd_rt5 actual=%h required=%h", rtData, mReg[5]); end
    checks++; if (wrCount !== 32'd1) begin errors++; $display("[TB] FAIL count_one actual=%h required=%h", wrCount, 32'd1); end
    @(negedge clk);
  endtask

  task automatic test_bypass;
    RegWrite = 1'b1; wrAddr = 5'd7; wrData = 32'h1234;
    rsAddr = 5'd7; rtAddr = 5'd7;
    #1;
    checks++; if (rsData !== 32'h1234) begin errors++; $display("[TB] FAIL byp_rs actual=%h required=%h", rsData, 32'h1234); end
    checks++; if (rtData !== 32'h1234) begin errors++; $display("[TB] FAIL byp_rt actual=%h required=%h", rtData, 32'h1234); end
    rtAddr = 5'd5;
    #1;
    checks++; if (rtData !== mReg[5]) begin errors++; $display("[TB] FAIL byp_rt_indep actual=%h required=%h", rtData, mReg[5]); end
    @(posedge clk);
    mReg[7] = 32'h1234;
    mCount  = mCount + 32'd1;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    checks++; if (rsData !== mReg[7]) begin errors++; $display("[TB] FAIL byp_stored actual=%h required=%h", rsData, mReg[7]); end
    @(negedge clk);
  endtask

  task automatic test_ra;
    RegWrite = 1'b1; wrAddr = 5'd31; wrData = 32'h00400010;
    #1;
    checks++; if (raData !== 32'h00400010) begin errors++; $display("[TB] FAIL ra_bypass actual=%h required=%h", raData, 32'h00400010); end
    @(posedge clk);
    mReg[31] = 32'h00400010;
    mCount   = mCount + 32'd1;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    checks++; if (raData !== mReg[31]) begin errors++; $display("[TB] FAIL ra_stored actual=%h required=%h", raData, mReg[31]); end
    @(negedge clk);
  endtask

  task automatic test_debug;
    RegWrite = 1'b1; wrAddr = 5'd5; wrData = 32'hA5A5;
    dbgReq = 1'b1; dbgAddr = 5'd5;
    expQ.push_back(32'hA5A5);
    @(posedge clk);
    mReg[5] = 32'hA5A5;
    mCount  = mCount + 32'd1;
    @(negedge clk);
    checks++; if (dbgValid !== 1'b1) begin errors++; $display("[TB] FAIL dbg_valid actual=%b required=1", dbgValid); end
    expVal = (expQ.size() > 0) ? expQ.pop_front() : 32'hXXXXXXXX;
    checks++; if (dbgData !== expVal) begin errors++; $display("[TB] FAIL dbg_data actual=%h required=%h", dbgData, expVal); end
    RegWrite = 1'b0;
    dbgReq   = 1'b0;
    @(negedge clk);
    checks++; if (dbgValid !== 1'b0) begin errors++; $display("[TB] FAIL dbg_valid_drop actual=%b required=0", dbgValid); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] addrs [4];
    addrs[0] = 5'd0; addrs[1] = 5'd7; addrs[2] = 5'd31; addrs[3] = 5'd5;
    doWrite(5'd0, 32'hCAFE0000);
    for (int i = 0; i < 4; i++) begin
      dbgReq  = 1'b1;
      dbgAddr = addrs[i];
      expQ.push_back(mReg[addrs[i]]);
      @(negedge clk);
      checks++; if (dbgValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d actual=%b required=1", i, dbgValid); end
      expVal = (expQ.size() > 0) ? expQ.pop_front() : 32'hXXXXXXXX;
      checks++; if (dbgData !== expVal) begin errors++; $display("[TB] FAIL b2b_data%0d actual=%h required=%h", i, dbgData, expVal); end
    end
    dbgReq = 1'b0;
    rsAddr = 5'd0;
    #1;
    checks++; if (rsData !== 32'hCAFE0000) begin errors++; $display("[TB] FAIL r0_writable actual=%h required=%h", rsData, 32'hCAFE0000); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    while (mCount < 32'd9) doWrite(5'd3, 32'h55);
    doWrite(5'd3, 32'h55);
    rsAddr = 5'd3;
    dbgReq = 1'b1; dbgAddr = 5'd3;
    #1;
    checks++; if (wrCount !== 32'd10) begin errors++; $display("[TB] FAIL pre_rst_count actual=%h required=%h", wrCount, 32'd10); end
    @(negedge clk);
    dbgReq = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
    mCount = 32'd0;
    #1;
    checks++; if (rsData !== 32'd0) begin errors++; $display("[TB] FAIL rst_async_r3 actual=%h required=%h", rsData, 32'd0); end
    checks++; if (wrCount !== 32'd0) begin errors++; $display("[TB] FAIL rst_async_count actual=%h required=%h", wrCount, 32'd0); end
    checks++; if (dbgValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_dbg actual=%b required=0", dbgValid); end
    @(negedge clk);
    RegWrite = 1'b1; wrAddr = 5'd3; wrData = 32'h77;
    dbgReq = 1'b1; dbgAddr = 5'd3;
    @(negedge clk);
    RegWrite = 1'b0;
    dbgReq   = 1'b0;
    #1;
    checks++; if (rsData !== 32'd0) begin errors++; $display("[TB] FAIL rst_nowrite actual=%h required=%h", rsData, 32'd0); end
    checks++; if (wrCount !== 32'd0) begin errors++; $display("[TB] FAIL rst_nocount actual=%h required=%h", wrCount, 32'd0); end
    checks++; if (dbgValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_nodbg actual=%b required=0", dbgValid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    force dut.r_wrCount = 32'hFFFFFFFF;
    #1;
    release dut.r_wrCount;
    doWrite(5'd9, 32'h9);
    #1;
    checks++; if (wrCount !== 32'd0) begin errors++; $display("[TB] FAIL count_wrap actual=%h required=%h", wrCount, 32'd0); end
    doWrite(5'd9, 32'h9);
    #1;
    checks++; if (wrCount !== 32'd1) begin errors++; $display("[TB] FAIL count_same_data actual=%h required=%h", wrCount, 32'd1); end
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; wrAddr = '0; wrData = '0;
    rsAddr = '0; rtAddr = '0; dbgReq = 1'b0; dbgAddr = '0;
    for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
    mCount = 32'd0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_ra();
    test_debug();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
